// File: rtl/mar_ctrl_if.sv
// Memory-port bundle between mar_ctrl (master) and the memory (slave).
interface mar_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] MAR_OUT;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic              MEM_ACK;

    modport master (output MAR_OUT, MEM_REQ, MEM_WE, input MEM_ACK);
    modport slave  (input MAR_OUT, MEM_REQ, MEM_WE, output MEM_ACK);
endinterface

// File: rtl/mar_ctrl.sv
// Memory address register with PC/MBR/increment source select and a
// req/ack memory handshake with timeout. MAR_CTRL_BOUND_CHK_EN adds a LIMIT check on request start.
module mar_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int CON_W    = 32,
    parameter int B_LD_MBR = 8,
    parameter int B_LD_PC  = 1,
    parameter int B_INC    = 12,
    parameter int B_RD     = 13,
    parameter int B_WR     = 14,
    parameter int TMO      = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CON_W-1:0]  CON,
    input  logic [ADDR_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] MBR_IN,
    mar_ctrl_if.master        mem,
    output logic              BUSY,
    output logic              DONE,
    output logic              TMO_ERR
`ifdef MAR_CTRL_BOUND_CHK_EN
    ,
    input  logic [ADDR_W-1:0] LIMIT,
    output logic              BOUND_ERR
`endif
);
    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              start;
`ifdef MAR_CTRL_BOUND_CHK_EN
    logic              bnd_q, bnd_d;
`endif

    assign start = CON[B_RD] | CON[B_WR];

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
`ifdef MAR_CTRL_BOUND_CHK_EN
        bnd_d   = bnd_q;
`endif
        case (state_q)
            IDLE: begin
                if (CON[B_LD_PC])       mar_d = PC_IN;
                else if (CON[B_LD_MBR]) mar_d = MBR_IN[ADDR_W-1:0];
                else if (CON[B_INC])    mar_d = mar_q + 1'b1;
                // Request carries the address loaded on this same edge.
                if (start) begin
`ifdef MAR_CTRL_BOUND_CHK_EN
                    if (mar_d > LIMIT) bnd_d = 1'b1;
                    else
`endif
                    begin
                        state_d = ACCESS;
                        we_d    = CON[B_WR];
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem.MEM_ACK) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_W'(TMO - 1)) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            mar_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef MAR_CTRL_BOUND_CHK_EN
            bnd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
`ifdef MAR_CTRL_BOUND_CHK_EN
            bnd_q   <= bnd_d;
`endif
        end
    end

    assign mem.MAR_OUT = mar_q;
    assign mem.MEM_REQ = (state_q == ACCESS);
    assign mem.MEM_WE  = we_q;
    assign BUSY        = (state_q == ACCESS);
    assign DONE        = done_q;
    assign TMO_ERR     = tmo_q;
`ifdef MAR_CTRL_BOUND_CHK_EN
    assign BOUND_ERR   = bnd_q;
`endif

    // Only a handful of CON bits and the low MBR byte are decoded here.
    logic unused_bits;
    assign unused_bits = ^{CON, MBR_IN};
endmodule

// File: tb/tb_mar_ctrl.sv
// Directed bench for mar_ctrl: reset, source priority, wrap, read/write
// handshake, timeout, back-to-back, reset mid-access, optional bound check.
module tb_mar_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] CON = '0;
    logic [7:0]  PC_IN = '0;
    logic [15:0] MBR_IN = '0;
    logic        BUSY, DONE, TMO_ERR;
`ifdef MAR_CTRL_BOUND_CHK_EN
    logic [7:0]  LIMIT = 8'hFF;
    logic        BOUND_ERR;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] LD_PC  = 32'h1 << 1;
    localparam logic [31:0] LD_MBR = 32'h1 << 8;
    localparam logic [31:0] INC    = 32'h1 << 12;
    localparam logic [31:0] RD     = 32'h1 << 13;
    localparam logic [31:0] WR     = 32'h1 << 14;

    mar_ctrl_if #(.ADDR_W(8)) mem ();

    mar_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .CON     (CON),
        .PC_IN   (PC_IN),
        .MBR_IN  (MBR_IN),
        .mem     (mem.master),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .TMO_ERR (TMO_ERR)
`ifdef MAR_CTRL_BOUND_CHK_EN
        ,
        .LIMIT     (LIMIT),
        .BOUND_ERR (BOUND_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, " mar"},  32'(mem.MAR_OUT), 32'h00);
        chk({tag, " req"},  32'(mem.MEM_REQ), 32'h0);
        chk({tag, " we"},   32'(mem.MEM_WE),  32'h0);
        chk({tag, " busy"}, 32'(BUSY),        32'h0);
        chk({tag, " done"}, 32'(DONE),        32'h0);
        chk({tag, " tmo"},  32'(TMO_ERR),     32'h0);
    endtask

    initial begin
        mem.MEM_ACK = 1'b0;

        // Reset asserted mid-cycle, checked before the next edge
        #2 RST = 1'b1;
        #1 chk_idle_reset("reset");
        #10 RST = 1'b0;

        // Source priority: PC beats MBR; MBR low byte alone
        PC_IN = 8'h3C; MBR_IN = 16'h12A5; CON = LD_PC | LD_MBR;
        tick(); chk("prio pc", 32'(mem.MAR_OUT), 32'h3C);
        CON = LD_MBR;
        tick(); chk("ld mbr", 32'(mem.MAR_OUT), 32'hA5);

        // Increment wrap
        PC_IN = 8'hFF; CON = LD_PC;
        tick(); chk("ld ff", 32'(mem.MAR_OUT), 32'hFF);
        CON = INC;
        tick(); chk("wrap 0", 32'(mem.MAR_OUT), 32'h00);
        tick(); chk("wrap 1", 32'(mem.MAR_OUT), 32'h01);

        // Read with load on the same edge; MAR frozen while busy
        PC_IN = 8'h40; CON = LD_PC | RD;
        tick();
        chk("rd mar", 32'(mem.MAR_OUT), 32'h40);
        chk("rd req", 32'(mem.MEM_REQ), 32'h1);
        chk("rd we",  32'(mem.MEM_WE),  32'h0);
        chk("rd busy", 32'(BUSY), 32'h1);
        CON = LD_MBR;
        tick(); chk("rd frozen", 32'(mem.MAR_OUT), 32'h40);
        CON = '0;
        tick(); chk("rd wait", 32'(mem.MEM_REQ), 32'h1);
        mem.MEM_ACK = 1'b1;
        tick();
        chk("rd done", 32'(DONE), 32'h1);
        chk("rd busy0", 32'(BUSY), 32'h0);
        chk("rd req0", 32'(mem.MEM_REQ), 32'h0);
        chk("rd mar hold", 32'(mem.MAR_OUT), 32'h40);
        mem.MEM_ACK = 1'b0;
        tick(); chk("rd done pulse", 32'(DONE), 32'h0);

        // Write timeout: request held 15 cycles then dropped
        CON = WR;
        tick();
        chk("wr req", 32'(mem.MEM_REQ), 32'h1);
        chk("wr we",  32'(mem.MEM_WE),  32'h1);
        CON = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo hold req", 32'(mem.MEM_REQ), 32'h1);
            chk("tmo no done", 32'(DONE), 32'h0);
        end
        tick();
        chk("tmo req0", 32'(mem.MEM_REQ), 32'h0);
        chk("tmo we0",  32'(mem.MEM_WE),  32'h0);
        chk("tmo busy0", 32'(BUSY), 32'h0);
        chk("tmo err", 32'(TMO_ERR), 32'h1);
        chk("tmo done0", 32'(DONE), 32'h0);
        tick(); chk("tmo done1", 32'(DONE), 32'h0);

        // Read after timeout completes; sticky error stays
        CON = RD;
        tick(); chk("rd2 req", 32'(mem.MEM_REQ), 32'h1);
        CON = '0; mem.MEM_ACK = 1'b1;
        tick();
        chk("rd2 done", 32'(DONE), 32'h1);
        chk("rd2 tmo sticky", 32'(TMO_ERR), 32'h1);

        // Back-to-back: RD+WR issued while DONE is high, write wins
        mem.MEM_ACK = 1'b0; CON = RD | WR;
        tick();
        chk("b2b req", 32'(mem.MEM_REQ), 32'h1);
        chk("b2b we",  32'(mem.MEM_WE),  32'h1);
        CON = '0; mem.MEM_ACK = 1'b1;
        tick(); chk("b2b done", 32'(DONE), 32'h1);

        // Ack while idle is ignored
        tick(); chk("idle ack", 32'(DONE), 32'h0);
        mem.MEM_ACK = 1'b0;

        // Reset mid-access
        PC_IN = 8'h22; CON = LD_PC | RD;
        tick(); chk("pre rst busy", 32'(BUSY), 32'h1);
        CON = '0;
        #2 RST = 1'b1;
        #1 chk_idle_reset("mid rst");
        @(posedge CLK); #1 RST = 1'b0;
        CON = RD;
        tick();
        chk("post rst req", 32'(mem.MEM_REQ), 32'h1);
        chk("post rst mar", 32'(mem.MAR_OUT), 32'h00);
        CON = '0; mem.MEM_ACK = 1'b1;
        tick(); chk("post rst done", 32'(DONE), 32'h1);
        mem.MEM_ACK = 1'b0;

`ifdef MAR_CTRL_BOUND_CHK_EN
        LIMIT = 8'h7F; PC_IN = 8'h80; CON = LD_PC | RD;
        tick();
        chk("bnd req0", 32'(mem.MEM_REQ), 32'h0);
        chk("bnd mar",  32'(mem.MAR_OUT), 32'h80);
        chk("bnd err",  32'(BOUND_ERR), 32'h1);
        CON = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mar_ctrl.md
Name: mar_ctrl

Overview:
- Parametrised memory address register with an integrated memory-access handshake. Successor to the CPU's single 8-bit MAR.
- Selects the next address from PC, MBR or a self-increment, decoded from the 32-bit control word.
- Holds the address stable while a read or write request is outstanding to the memory.
- Sits between the control unit (CON), PC, MBR and the memory port.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 16: MBR width; MAR loads MBR_IN[ADDR_W-1:0].
- CON_W, 32: control word width.
- B_LD_MBR, 8: CON bit, load from MBR.
- B_LD_PC, 1: CON bit, load from PC.
- B_INC, 12: CON bit, MAR <= MAR+1.
- B_RD, 13: CON bit, start memory read.
- B_WR, 14: CON bit, start memory write.
- TMO, 15: cycles to wait for MEM_ACK before abort (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CON  in  CON_W  control word from control unit.
- PC_IN  in  ADDR_W  program counter.
- MBR_IN  in  DATA_W  memory buffer register.
- MEM_ACK  in  1  memory completes current access.
- MAR_OUT  out  ADDR_W  registered address to memory.
- MEM_REQ  out  1  access request, held until ack/timeout.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ.
- BUSY  out  1  access outstanding.
- DONE  out  1  one-cycle pulse on acknowledged completion.
- TMO_ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (RST async, active-high): MAR_OUT=0, MEM_REQ=0, MEM_WE=0, BUSY=0, DONE=0, TMO_ERR=0, FSM=IDLE, timeout counter=0.
- Address update priority, same cycle: B_LD_PC > B_LD_MBR > B_INC. Only one source is taken per edge.
- Increment wraps modulo 2^ADDR_W (all-ones -> 0).
- Address updates take effect one cycle after the CON edge and occur only in IDLE.
- In ACCESS, all load/inc bits are ignored and MAR_OUT is frozen.
- FSM IDLE:
  - B_RD or B_WR set -> ACCESS. MEM_REQ=1, BUSY=1, MEM_WE=B_WR, counter=0.
  - B_RD and B_WR both set -> write wins.
  - A load in the same cycle as RD/WR is applied first. The request carries the newly loaded address, which is visible on MAR_OUT in the same cycle as MEM_REQ.
- FSM ACCESS:
  - MEM_ACK=1 -> IDLE. MEM_REQ=0, BUSY=0, MEM_WE=0, DONE=1 for exactly one cycle.
  - Otherwise the counter increments. When the counter reaches TMO-1 with no ack -> IDLE, request dropped, TMO_ERR=1, DONE stays 0.
- MEM_ACK while IDLE is ignored.
- A new RD/WR in the cycle DONE is high is accepted (back-to-back): state returns to ACCESS on the next edge.
- TMO_ERR clears only on RST.
- RST asserted mid-access aborts immediately; all outputs take their reset values, with no DONE pulse.

Optional Feature:
- Macro: MAR_CTRL_BOUND_CHK_EN.
- Defined:
  - Adds input LIMIT [ADDR_W-1:0] and output BOUND_ERR (sticky, reset 0).
  - A RD/WR start with the effective address > LIMIT is refused: FSM stays IDLE, no MEM_REQ, BOUND_ERR=1.
  - Loads and increments are still performed.
- Undefined: the port and logic are absent, and every request is issued.

Test Plan:
- Reset then idle: RST pulse mid-cycle -> MAR_OUT=0x00, all flags 0, asynchronously before the next edge.
- Priority: CON bits 1 and 8 both set, PC_IN=0x3C, MBR_IN=0x12A5 -> MAR_OUT=0x3C. Bit 8 alone -> MAR_OUT=0xA5.
- Wrap: MAR=0xFF, B_INC -> 0x00. Next B_INC -> 0x01.
- Read handshake:
  - Load PC=0x40 plus B_RD -> MEM_REQ=1, MEM_WE=0, MAR_OUT=0x40.
  - A B_LD_MBR during the wait leaves MAR_OUT=0x40.
  - MEM_ACK after 3 cycles -> DONE pulses 1 cycle, BUSY=0.
- Timeout: B_WR with MEM_ACK held 0 -> MEM_REQ drops after 15 cycles, TMO_ERR=1, DONE never pulses. A subsequent read with ack completes normally while TMO_ERR stays 1.
- Reset mid-access: assert RST while BUSY=1 -> MEM_REQ=0, BUSY=0 immediately. After release a B_RD is accepted. With MAR_CTRL_BOUND_CHK_EN, LIMIT=0x7F and address 0x80 -> no request, BOUND_ERR=1.
